// File: rtl/noise_scale_offset.sv
// noise_scale_offset
//
// Three-stage, multi-channel fixed-point scale-and-offset stage. Each sample
// is multiplied by its channel's signed scale (FRAC_W fractional bits). The
// product is re-aligned to DATA_W bits and summed with the channel's signed
// offset.
//
// Optional feature macro: NOISE_SCALE_SAT_EN
//   defined   -> the slice step and the add step clamp to the signed DATA_W
//                range, and out_sat flags any clamped result
//   undefined -> both steps wrap, and out_sat is tied to 0
//
// Ports
//   CLK, RST        single rising-edge clock, synchronous active-high reset
//   cfg_we/sel/ch/data  coefficient write (sel 0 = scale, 1 = offset);
//                   writes to channels >= NUM_CH are dropped
//   in_valid/in_ready/in_data/in_ch      sample input stream
//   out_valid/out_ready/out_data/out_ch  result output stream
//   out_sat         result was clamped (saturation build only)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. The producer holds valid and payload until that edge. The whole
// pipeline advances on en = out_ready || !out_valid, and in_ready = en.
// While en is low every stage holds, so the output payload stays stable.

module noise_scale_offset #(
    parameter int DATA_W  = 32,
    parameter int SCALE_W = 32,
    parameter int FRAC_W  = 24,
    parameter int NUM_CH  = 4,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CFG_W   = (DATA_W > SCALE_W) ? DATA_W : SCALE_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_sat
);

    localparam int PW       = DATA_W + SCALE_W;
    localparam int SLICE_LO = FRAC_W;
    localparam int SLICE_HI = FRAC_W + DATA_W - 1;

    localparam logic [SCALE_W-1:0] SCALE_ONE  = SCALE_W'(1) << FRAC_W;
    localparam logic [CH_W:0]      NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

    // ------------------------------------------------------------------
    // Global enable
    // ------------------------------------------------------------------
    logic en;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Per-channel coefficient registers
    // ------------------------------------------------------------------
    logic [SCALE_W-1:0] scale_q  [NUM_CH];
    logic [DATA_W-1:0]  offset_q [NUM_CH];
    logic               cfg_in_range;
    logic               rd_in_range;
    logic [CH_W-1:0]    rd_ch;

    assign cfg_in_range = ({1'b0, cfg_ch} < NUM_CH_EXT);
    assign rd_in_range  = ({1'b0, in_ch} < NUM_CH_EXT);
    // Samples tagged with a channel that does not exist borrow channel 0.
    assign rd_ch        = rd_in_range ? in_ch : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                scale_q[i]  <= SCALE_ONE;
                offset_q[i] <= '0;
            end
        end else if (cfg_we && cfg_in_range) begin
            if (cfg_sel) begin
                offset_q[cfg_ch] <= cfg_data[DATA_W-1:0];
            end else begin
                scale_q[cfg_ch] <= cfg_data[SCALE_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // S1: register sample and fetch its coefficients. The coefficient
    // arrays update on the same edge, so a write that coincides with an
    // accepted sample is not seen by that sample.
    // ------------------------------------------------------------------
    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    logic [CH_W-1:0]    s1_ch;
    logic [SCALE_W-1:0] s1_scale;
    logic [DATA_W-1:0]  s1_offset;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_ch     <= '0;
            s1_scale  <= '0;
            s1_offset <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_data   <= in_data;
            s1_ch     <= in_ch;
            s1_scale  <= scale_q[rd_ch];
            s1_offset <= offset_q[rd_ch];
        end
    end

    // ------------------------------------------------------------------
    // S2: full-width signed product. Both operands are sign-extended to
    // PW bits, so the low PW bits of the unsigned product are the exact
    // signed product.
    // ------------------------------------------------------------------
    logic [PW-1:0]     data_ext;
    logic [PW-1:0]     scale_ext;
    logic [PW-1:0]     prod_c;
    logic              s2_valid;
    logic [PW-1:0]     s2_prod;
    logic [CH_W-1:0]   s2_ch;
    logic [DATA_W-1:0] s2_offset;

    assign data_ext  = {{SCALE_W{s1_data[DATA_W-1]}}, s1_data};
    assign scale_ext = {{DATA_W{s1_scale[SCALE_W-1]}}, s1_scale};
    assign prod_c    = data_ext * scale_ext;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_ch     <= '0;
            s2_offset <= '0;
        end else if (en) begin
            s2_valid  <= s1_valid;
            s2_prod   <= prod_c;
            s2_ch     <= s1_ch;
            s2_offset <= s1_offset;
        end
    end

    // ------------------------------------------------------------------
    // S3: slice, add offset, register outputs
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] slice;
    logic [DATA_W-1:0] res;
    logic              res_sat;

    assign slice = s2_prod[SLICE_HI:SLICE_LO];

`ifdef NOISE_SCALE_SAT_EN
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic [PW-1-SLICE_HI:0] upper;
    logic                   slice_ovf;
    logic [DATA_W-1:0]      slice_c;
    logic [DATA_W:0]        sum_ext;
    logic                   sum_ovf;
    logic                   unused_bits;

    // The slice is representable only when every bit above it, including
    // its own sign bit, carries the same value.
    assign upper     = s2_prod[PW-1:SLICE_HI];
    assign slice_ovf = !((&upper) || (~|upper));
    assign slice_c   = slice_ovf ? (s2_prod[PW-1] ? MIN_V : MAX_V) : slice;

    // One guard bit: overflow shows up as the two top bits disagreeing,
    // and the guard bit then holds the true sign.
    assign sum_ext   = {slice_c[DATA_W-1], slice_c} + {s2_offset[DATA_W-1], s2_offset};
    assign sum_ovf   = sum_ext[DATA_W] ^ sum_ext[DATA_W-1];

    assign res       = sum_ovf ? (sum_ext[DATA_W] ? MIN_V : MAX_V) : sum_ext[DATA_W-1:0];
    assign res_sat   = slice_ovf || sum_ovf;

    assign unused_bits = ^s2_prod[SLICE_LO-1:0];
`else
    logic unused_bits;

    assign res         = slice + s2_offset;
    assign res_sat     = 1'b0;
    assign unused_bits = ^{s2_prod[SLICE_LO-1:0], s2_prod[PW-1:SLICE_HI+1], res_sat};
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            out_data  <= res;
            out_ch    <= s2_ch;
        end
    end

`ifdef NOISE_SCALE_SAT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_sat <= 1'b0;
        end else if (en) begin
            out_sat <= res_sat;
        end
    end
`else
    assign out_sat = 1'b0;
`endif

endmodule

// File: doc/noise_scale_offset.md
# noise_scale_offset

Multi-channel, pipelined fixed-point scale-and-offset stage for the noise generator datapath. Each sample read from the noise table BRAM is multiplied by a per-channel signed scale (Q(DATA_W-FRAC_W).FRAC_W), re-aligned to DATA_W bits, and summed with a per-channel signed offset written over the AXI-lite register path. It sits between the BRAM sample reader and the channel-sounder transmit stream.

## Interface
- DATA_W, 32, sample, offset and output width (two's complement).
- SCALE_W, 32, scale coefficient width (two's complement).
- FRAC_W, 24, fractional bits of scale; product slice is [FRAC_W+DATA_W-1:FRAC_W].
- NUM_CH, 4, number of channels, each with its own scale/offset pair (≥1).
- CH_W, $clog2(NUM_CH) (min 1), channel tag width.
- CLK  in  1  single clock, all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cfg_we  in  1  coefficient write strobe.
- cfg_sel  in  1  0 = scale, 1 = offset.
- cfg_ch  in  CH_W  channel written; values ≥ NUM_CH are ignored.
- cfg_data  in  max(DATA_W,SCALE_W)  value written; low bits are used.
- in_valid  in  1  input sample valid.
- in_ready  out  1  stage accepts the input sample this cycle.
- in_data  in  DATA_W  BRAM sample.
- in_ch  in  CH_W  channel tag of the sample.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  result.
- out_ch  out  CH_W  channel tag, carried unchanged.
- out_sat  out  1  result was clamped (only with saturation built in).

## Operation
- Reset:
  - every scale = 1.0 (1<<FRAC_W); every offset = 0.
  - out_valid = 0, out_data = 0, out_ch = 0, out_sat = 0.
  - all internal valids cleared; in-flight samples are dropped.
- Pipeline: S1 registers the sample and fetches its channel's coefficients; S2 registers the full DATA_W+SCALE_W signed product; S3 slices, adds the offset and registers the outputs.
- Transfer: a sample is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Stall: global enable en = out_ready || !out_valid; in_ready = en. When en = 0, every stage holds its contents and out_data, out_ch and out_sat stay stable.
- Config writes take effect on the next edge. A write and an accepted sample on the same channel in the same cycle: the sample uses the old value.
- Out-of-range cfg_ch writes are dropped. An in_ch ≥ NUM_CH uses channel 0's coefficients.
- Arithmetic without saturation: out = product[FRAC_W+DATA_W-1:FRAC_W] + offset, truncated to DATA_W bits (wraps).

## Timing
- Latency: 3 cycles from acceptance to out_valid, with no stall.
- Throughput: 1 sample per cycle while out_ready = 1.
- Bubbles (in_valid = 0) propagate as out_valid = 0 and do not stall the pipeline.
- RST asserted mid-stream: on the next edge the pipeline is empty and the coefficients are back at their defaults.

## Configuration
- NOISE_SCALE_SAT_EN defined: both steps are clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Slice step: clamp if product bits above the slice differ from the slice sign bit.
  - Add step: clamp on signed overflow of the sum.
  - out_sat = 1 for any clamped result, registered with out_data.
- NOISE_SCALE_SAT_EN undefined: slice and sum wrap, and out_sat is tied to 0.

## Test plan
- Nominal: ch0 scale=0x64000000 (100.0), offset=0x0002BFFC, in_data=0x00001229.
  - Required: out_data=0x0009D800, out_ch=0, out_valid 3 cycles after acceptance.
- Per-channel: ch1 scale=0x00800000 (0.5), offset=0; ch2 scale=0xFF000000 (-1.0), offset=0x10. Back-to-back samples 0x100 on ch1, then ch2.
  - Required: 0x80 then 0xFFFFFF10, consecutive cycles, tags preserved.
- Overflow: ch3 scale=0x02000000 (2.0), offset=0, in_data=0x7FFFFFFF.
  - With NOISE_SCALE_SAT_EN: 0x7FFFFFFF, out_sat=1.
  - Without it: 0xFFFFFFFE, out_sat=0.
- Backpressure: stream 8 samples with out_ready low for 5 cycles mid-stream.
  - Required: in_ready low whenever out_valid && !out_ready; output held stable; all 8 results in order, none lost or duplicated.
- Config race: write ch0 offset=0x5 in the same cycle a ch0 sample (scale 1.0, data 0x1) is accepted, then send a second sample (data 0x1).
  - Required: 0x1 then 0x6.
- Reset mid-stream: assert RST for 1 cycle with 3 samples in flight.
  - Required: out_valid=0 on the next cycle and none of those samples emerges.
  - A following sample uses scale 1.0 / offset 0.
